// File: rtl/nerv_dmem_bridge.sv
// Bridges the NERV core data port onto a valid/ready request bus with a separate response strobe.
// Optional watchdog: define NERV_DMEM_BRIDGE_TIMEOUT_EN to force completion after TIMEOUT_CYCLES.
module nerv_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_load_s;

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        timeout_s;

    assign timeout_s = (cnt_q == TO_LAST);
    assign bus_err   = err_q;
`else
    assign bus_err   = 1'b0;
`endif

    assign is_load_s  = (wstrb_q == 4'd0);
    assign bus_addr   = addr_q;
    assign bus_wstrb  = wstrb_q;
    assign bus_wdata  = wdata_q;
    assign dmem_rdata = rdata_q;

    // Next-state, capture and handshake outputs
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        stall         = 1'b0;
        bus_req_valid = 1'b0;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                stall = dmem_valid;
                if (dmem_valid) begin
                    state_d = S_REQ;
                    addr_d  = dmem_addr & 32'hFFFF_FFFC;
                    wstrb_d = dmem_wstrb;
                    wdata_d = dmem_wdata;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
                    cnt_d   = 16'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                stall         = 1'b1;
                bus_req_valid = 1'b1;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
                cnt_d         = cnt_q + 16'd1;
`endif
                // A same-cycle accept and response skips WAIT entirely
                if (bus_req_ready && bus_rsp_valid) begin
                    state_d = S_DONE;
                    rdata_d = is_load_s ? bus_rsp_rdata : rdata_q;
                end
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
                else if (timeout_s) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = is_load_s ? 32'hFFFF_FFFF : rdata_q;
                end
`endif
                else if (bus_req_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (bus_rsp_valid) begin
                    state_d = S_DONE;
                    rdata_d = is_load_s ? bus_rsp_rdata : rdata_q;
                end
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
                else if (timeout_s) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = is_load_s ? 32'hFFFF_FFFF : rdata_q;
                end
`endif
                else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                // The core still presents the retiring request here; it is not re-issued
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_nerv_dmem_bridge.sv
// Directed self-checking bench for nerv_dmem_bridge; inputs change 1ns after the rising edge.
module tb_nerv_dmem_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    nerv_dmem_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .dmem_valid    (dmem_valid),
        .dmem_addr     (dmem_addr),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_addr      (bus_addr),
        .bus_wstrb     (bus_wstrb),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_err       (bus_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        dmem_valid    = 1'b0;
        dmem_addr     = 32'd0;
        dmem_wstrb    = 4'd0;
        dmem_wdata    = 32'd0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_rdata = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_cmp++; if (bus_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", bus_req_valid); end
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus_err); end
        n_cmp++; if (dmem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 00000000", dmem_rdata); end
        n_cmp++; if ({bus_addr, bus_wstrb, bus_wdata} !== 68'h0) begin n_bad++; $display("FAIL rst_capture: got %h %h %h want zeros", bus_addr, bus_wstrb, bus_wdata); end
        dmem_valid = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall_follow: got %b want 1", stall); end
        dmem_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        dmem_valid = 1'b1; dmem_addr = 32'h0000_1003; dmem_wstrb = 4'd0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_idle_stall: got %b want 1", stall); end
        tick();
        n_cmp++; if (bus_req_valid !== 1'b1) begin n_bad++; $display("FAIL load_req_valid: got %b want 1", bus_req_valid); end
        n_cmp++; if (bus_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL load_addr: got %h want 00001000", bus_addr); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_req_stall: got %b want 1", stall); end
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hCAFE_F00D;
        tick();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL load_done_stall: got %b want 0", stall); end
        n_cmp++; if (dmem_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL load_rdata: got %h want cafef00d", dmem_rdata); end
        n_cmp++; if (bus_req_valid !== 1'b0) begin n_bad++; $display("FAIL load_done_req: got %b want 0", bus_req_valid); end
        tick();
        dmem_valid = 1'b0;
        // stray response while idle must be ignored
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        bus_rsp_valid = 1'b0;
        tick();
        n_cmp++; if (dmem_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL idle_rsp_drop: got %h want cafef00d", dmem_rdata); end
        n_cmp++; if ({stall, bus_req_valid} !== 2'b00) begin n_bad++; $display("FAIL idle_rsp_state: got %b want 00", {stall, bus_req_valid}); end
    endtask

    task automatic test_store();
        int stall_cnt;
        int req_cnt;
        int bad_stable;
        stall_cnt = 0; req_cnt = 0; bad_stable = 0;
        dmem_valid = 1'b1; dmem_addr = 32'h0000_2002; dmem_wstrb = 4'b0011; dmem_wdata = 32'h1234_5678;
        tick();
        for (int k = 0; k < 6; k++) begin
            bus_req_ready = (k == 3);
            bus_rsp_valid = (k == 5);
            bus_rsp_rdata = 32'hBAD0_BAD0;
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (bus_req_valid === 1'b1) begin
                req_cnt++;
                if ({bus_addr, bus_wstrb, bus_wdata} !== {32'h0000_2000, 4'b0011, 32'h1234_5678}) bad_stable++;
            end
            tick();
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        n_cmp++; if (req_cnt !== 4) begin n_bad++; $display("FAIL store_req_cycles: got %0d want 4", req_cnt); end
        n_cmp++; if (bad_stable !== 0) begin n_bad++; $display("FAIL store_req_stable: got %0d bad cycles want 0", bad_stable); end
        n_cmp++; if (stall_cnt !== 6) begin n_bad++; $display("FAIL store_stall_cycles: got %0d want 6", stall_cnt); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL store_done_stall: got %b want 0", stall); end
        n_cmp++; if (dmem_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL store_rdata_kept: got %h want cafef00d", dmem_rdata); end
        tick();
        dmem_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int reqs;
        reqs = 0;
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
        dmem_valid = 1'b1; dmem_wstrb = 4'd0;
        for (int c = 0; c < 9; c++) begin
            dmem_valid    = (c < 5);
            dmem_addr     = (c < 3) ? 32'h0000_0010 : 32'h0000_0020;
            bus_rsp_rdata = (c < 3) ? 32'h1111_1111 : 32'h2222_2222;
            #1;
            if (bus_req_valid === 1'b1) reqs++;
            if (c == 2) begin
                n_cmp++; if (dmem_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL b2b_first: got %h want 11111111", dmem_rdata); end
            end
            if (c == 4) begin
                n_cmp++; if (bus_addr !== 32'h0000_0020) begin n_bad++; $display("FAIL b2b_second_addr: got %h want 00000020", bus_addr); end
            end
            tick();
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        n_cmp++; if (reqs !== 2) begin n_bad++; $display("FAIL b2b_req_count: got %0d want 2", reqs); end
        n_cmp++; if (dmem_rdata !== 32'h2222_2222) begin n_bad++; $display("FAIL b2b_second: got %h want 22222222", dmem_rdata); end
    endtask

    task automatic test_reset_mid();
        dmem_valid = 1'b1; dmem_addr = 32'h0000_3000; dmem_wstrb = 4'd0;
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        dmem_valid = 1'b0;
        #1;
        n_cmp++; if ({stall, bus_req_valid} !== 2'b10) begin n_bad++; $display("FAIL mid_wait_state: got %b want 10", {stall, bus_req_valid}); end
        reset = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall: got %b want 0", stall); end
        n_cmp++; if (dmem_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rst_rdata: got %h want 00000000", dmem_rdata); end
        tick();
        reset = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h5555_AAAA;
        tick();
        bus_rsp_valid = 1'b0;
        tick();
        n_cmp++; if (dmem_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rsp_drop: got %h want 00000000", dmem_rdata); end
        n_cmp++; if ({stall, bus_req_valid} !== 2'b00) begin n_bad++; $display("FAIL mid_idle: got %b want 00", {stall, bus_req_valid}); end
        // a fresh request must be accepted straight away from IDLE
        dmem_valid = 1'b1; dmem_addr = 32'h0000_4000;
        tick();
        n_cmp++; if ({bus_req_valid, bus_addr} !== {1'b1, 32'h0000_4000}) begin n_bad++; $display("FAIL mid_new_req: got %b %h want 1 00004000", bus_req_valid, bus_addr); end
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0BAD_CAFE;
        tick();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; dmem_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int stall_cnt;
        int err_cnt;
        stall_cnt = 0; err_cnt = 0;
        dmem_valid = 1'b1; dmem_addr = 32'h0000_5000; dmem_wstrb = 4'd0;
        tick();
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            if (stall === 1'b1) stall_cnt++;
            if (bus_err !== 1'b0) err_cnt++;
            tick();
        end
        n_cmp++; if (stall_cnt !== 4) begin n_bad++; $display("FAIL to_stall_cycles: got %0d want 4", stall_cnt); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL to_early_err: got %0d want 0", err_cnt); end
        n_cmp++; if ({stall, bus_req_valid, bus_err} !== 3'b001) begin n_bad++; $display("FAIL to_done: got %b want 001", {stall, bus_req_valid, bus_err}); end
        n_cmp++; if (dmem_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_rdata: got %h want ffffffff", dmem_rdata); end
        dmem_valid = 1'b0;
        tick();
        n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", bus_err); end
`else
        for (int c = 0; c < 300; c++) begin
            if (stall === 1'b1) stall_cnt++;
            if (bus_err !== 1'b0) err_cnt++;
            tick();
        end
        n_cmp++; if (stall_cnt !== 300) begin n_bad++; $display("FAIL nto_stall: got %0d want 300", stall_cnt); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL nto_err: got %0d want 0", err_cnt); end
        bus_req_ready = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h7777_0001;
        tick();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; dmem_valid = 1'b0;
        n_cmp++; if ({stall, dmem_rdata} !== {1'b0, 32'h7777_0001}) begin n_bad++; $display("FAIL nto_complete: got %b %h want 0 77770001", stall, dmem_rdata); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
